// File: rtl/bomberman_pkg.sv
// Shared tile geometry and the bomb slot record used by the bomb queue.
package bomberman_pkg;

    localparam int TILE_W = 16;
    localparam int TILE_H = 16;
    localparam logic [9:0] TILE_MASK = 10'h3F0;

    // One entry of the bomb FIFO: tile origin plus remaining fuse ticks.
    typedef struct packed {
        logic       valid;
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] fuse;
    } slot_t;

    // Snap a sprite top-left coordinate to the tile under the sprite centre.
    // The add wraps in 10 bits on purpose, matching the pixel coordinate width.
    function automatic logic [9:0] snap_tile(input logic [9:0] pos);
        return (pos + 10'(TILE_W / 2)) & TILE_MASK;
    endfunction

endpackage

// File: rtl/bomb_queue_tick_gen.sv
// Fuse-tick prescaler: one single-cycle tick every TICK_DIV clocks.
module tick_gen #(
    parameter int TICK_DIV = 833333
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] count;

    assign tick = (count == CNT_W'(TICK_DIV - 1));

    // Free-running divider; restarts from zero after reset so the first tick lands TICK_DIV cycles later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/bomb_queue.sv
// Bomb placement queue: circular FIFO of live bombs with per-bomb fuses,
// one detonation per cycle from the head, and a pixel hit test for drawing.
module bomb_queue
    import bomberman_pkg::*;
#(
    parameter int MAX_BOMBS  = 4,
    parameter int FUSE_TICKS = 120,
    parameter int TICK_DIV   = 833333
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       C,
    input  logic [9:0] b_x,
    input  logic [9:0] b_y,
    input  logic [9:0] v_x,
    input  logic [9:0] v_y,
    output logic [9:0] exploding_bomb_x,
    output logic [9:0] exploding_bomb_y,
    output logic       explosion_write_enable,
    output logic       bomb_on,
    output logic [3:0] bomb_col,
    output logic [3:0] bomb_row,
    output logic [3:0] bomb_count
);

    localparam int PTR_W = (MAX_BOMBS > 1) ? $clog2(MAX_BOMBS) : 1;

    slot_t             slots [MAX_BOMBS];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic              c_q;
    logic              tick;
    logic [9:0]        place_x;
    logic [9:0]        place_y;
    logic              dup;
    logic              place_evt;
    logic              full;
    logic              pop;
    logic              push;

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    assign place_evt = C & ~c_q;
    assign full      = (bomb_count == 4'(MAX_BOMBS));
    assign pop       = slots[head].valid && (slots[head].fuse == 8'd0);
    assign push      = place_evt && !dup && (!full || pop);

    // Snap the requested tile and look for an existing bomb already on it.
    always_comb begin
        place_x = snap_tile(b_x);
        place_y = snap_tile(b_y);
        dup     = 1'b0;
        for (int i = 0; i < MAX_BOMBS; i++) begin
            if (slots[i].valid && slots[i].x == place_x && slots[i].y == place_y) begin
                dup = 1'b1;
            end
        end
    end

    // Fuse countdown, head detonation and tail insertion; a push into the slot being popped wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_BOMBS; i++) begin
                slots[i] <= '0;
            end
            head                   <= '0;
            tail                   <= '0;
            c_q                    <= 1'b0;
            bomb_count             <= 4'd0;
            exploding_bomb_x       <= 10'd0;
            exploding_bomb_y       <= 10'd0;
            explosion_write_enable <= 1'b0;
        end else begin
            c_q                    <= C;
            explosion_write_enable <= pop;
            for (int i = 0; i < MAX_BOMBS; i++) begin
                if (tick && slots[i].valid && slots[i].fuse != 8'd0) begin
                    slots[i].fuse <= slots[i].fuse - 8'd1;
                end
            end
            if (pop) begin
                slots[head].valid <= 1'b0;
                head              <= head + PTR_W'(1);
                exploding_bomb_x  <= slots[head].x;
                exploding_bomb_y  <= slots[head].y;
            end
            if (push) begin
                slots[tail] <= '{valid: 1'b1, x: place_x, y: place_y, fuse: 8'(FUSE_TICKS)};
                tail        <= tail + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   bomb_count <= bomb_count + 4'd1;
                2'b01:   bomb_count <= bomb_count - 4'd1;
                default: bomb_count <= bomb_count;
            endcase
        end
    end

    // Pixel hit test; scanning from the top index down lets the lowest matching slot win.
    always_comb begin
        logic [9:0] dx;
        logic [9:0] dy;
        bomb_on  = 1'b0;
        bomb_col = 4'd0;
        bomb_row = 4'd0;
        dx       = 10'd0;
        dy       = 10'd0;
        for (int i = MAX_BOMBS - 1; i >= 0; i--) begin
            dx = v_x - slots[i].x;
            dy = v_y - slots[i].y;
            if (slots[i].valid && v_x >= slots[i].x && v_y >= slots[i].y &&
                dx <= 10'(TILE_W - 1) && dy <= 10'(TILE_H - 1)) begin
                bomb_on  = 1'b1;
                bomb_col = dx[3:0];
                bomb_row = dy[3:0];
            end
        end
    end

endmodule

// File: tb/tb_bomb_queue.sv
// Directed bench for bomb_queue with a detonation scoreboard.
module tb_bomb_queue;

    localparam int MAX_BOMBS  = 4;
    localparam int FUSE_TICKS = 3;
    localparam int TICK_DIV   = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       C     = 1'b0;
    logic [9:0] b_x   = 10'd0;
    logic [9:0] b_y   = 10'd0;
    logic [9:0] v_x   = 10'd0;
    logic [9:0] v_y   = 10'd0;
    logic [9:0] exploding_bomb_x;
    logic [9:0] exploding_bomb_y;
    logic       explosion_write_enable;
    logic       bomb_on;
    logic [3:0] bomb_col;
    logic [3:0] bomb_row;
    logic [3:0] bomb_count;

    int          checks   = 0;
    int          failures = 0;
    int          lat;
    int          max_cnt;
    logic [19:0] exp_q [$];

    bomb_queue #(
        .MAX_BOMBS (MAX_BOMBS),
        .FUSE_TICKS(FUSE_TICKS),
        .TICK_DIV  (TICK_DIV)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .C                     (C),
        .b_x                   (b_x),
        .b_y                   (b_y),
        .v_x                   (v_x),
        .v_y                   (v_y),
        .exploding_bomb_x      (exploding_bomb_x),
        .exploding_bomb_y      (exploding_bomb_y),
        .explosion_write_enable(explosion_write_enable),
        .bomb_on               (bomb_on),
        .bomb_col              (bomb_col),
        .bomb_row              (bomb_row),
        .bomb_count            (bomb_count)
    );

    always #5 clk = ~clk;

    // Expected tile for a sprite position: centre snapped to the 16-px grid, 10-bit wrap.
    function automatic logic [9:0] snap(input logic [9:0] p);
        logic [9:0] s;
        s = p + 10'd8;
        return s & 10'h3F0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle press of C at the given sprite position; accepted bombs go on the scoreboard.
    task automatic applyStimulus(input logic [9:0] bx, input logic [9:0] by, input bit accept);
        b_x = bx;
        b_y = by;
        C   = 1'b1;
        if (accept) exp_q.push_back({snap(bx), snap(by)});
        @(negedge clk);
        C = 1'b0;
    endtask

    task automatic waitDrain(input string tag, input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checkOutput(tag, 32'(exp_q.size()), 0);
    endtask

    // Every detonation strobe must match the oldest outstanding expected tile.
    always @(negedge clk) begin
        if (reset === 1'b1 && explosion_write_enable === 1'b1) begin
            checkOutput("strobe_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                logic [19:0] e;
                e = exp_q.pop_front();
                checkOutput("strobe_x", exploding_bomb_x, e[19:10]);
                checkOutput("strobe_y", exploding_bomb_y, e[9:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        $display("[TB] bomb_queue bench start");

        // Reset state
        waitCycles(3);
        checkOutput("rst_count", bomb_count, 0);
        checkOutput("rst_strobe", explosion_write_enable, 0);
        checkOutput("rst_ex_x", exploding_bomb_x, 0);
        checkOutput("rst_ex_y", exploding_bomb_y, 0);
        checkOutput("rst_bomb_on", bomb_on, 0);

        // Single bomb with known tick phase: place edge is the first edge after release
        reset = 1'b1;
        v_x = 10'd100;
        v_y = 10'd60;
        applyStimulus(10'd100, 10'd50, 1'b1);
        checkOutput("t031_count_placed", bomb_count, 1);
        checkOutput("t035_on", bomb_on, 1);
        checkOutput("t035_col", bomb_col, 4);
        checkOutput("t035_row", bomb_row, 12);
        v_x = 10'd112; v_y = 10'd48; #1;
        checkOutput("t035_off_right", bomb_on, 0);
        checkOutput("t035_off_col", bomb_col, 0);
        v_x = 10'd96; v_y = 10'd48; #1;
        checkOutput("t035_corner_on", bomb_on, 1);
        v_x = 10'd111; v_y = 10'd63; #1;
        checkOutput("t035_far_corner_col", bomb_col, 15);
        checkOutput("t035_far_corner_row", bomb_row, 15);
        v_x = 10'd95; v_y = 10'd48; #1;
        checkOutput("t035_off_left", bomb_on, 0);
        lat = 1;
        while (explosion_write_enable !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("t031_strobe_latency", 32'(lat), 13);
        checkOutput("t031_ex_x", exploding_bomb_x, 96);
        checkOutput("t031_ex_y", exploding_bomb_y, 48);
        checkOutput("t031_count_after", bomb_count, 0);
        waitCycles(1);
        checkOutput("t031_strobe_single", explosion_write_enable, 0);
        waitCycles(3);
        checkOutput("t026_hold_x", exploding_bomb_x, 96);

        // Holding C places exactly one bomb
        b_x = 10'd200; b_y = 10'd200; C = 1'b1;
        exp_q.push_back({snap(10'd200), snap(10'd200)});
        max_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (32'(bomb_count) > max_cnt) max_cnt = 32'(bomb_count);
        end
        C = 1'b0;
        checkOutput("t032_hold_max_count", 32'(max_cnt), 1);
        waitCycles(1);
        checkOutput("t032_hold_drained", 32'(exp_q.size()), 0);
        applyStimulus(10'd200, 10'd200, 1'b1);
        waitCycles(1);
        applyStimulus(10'd200, 10'd200, 1'b0);
        checkOutput("t032_dup_count", bomb_count, 1);
        waitDrain("t032_drain", 40);

        // Five places inside 8 cycles: fifth sees a full queue
        applyStimulus(10'd39, 10'd24, 1'b1);   waitCycles(1);
        applyStimulus(10'd56, 10'd31, 1'b1);   waitCycles(1);
        applyStimulus(10'd100, 10'd20, 1'b1);  waitCycles(1);
        applyStimulus(10'd1015, 10'd1015, 1'b1); waitCycles(1);
        applyStimulus(10'd300, 10'd300, 1'b0);
        checkOutput("t033_full_count", bomb_count, 4);
        waitDrain("t033_drain", 60);
        checkOutput("t033_count_empty", bomb_count, 0);

        // Push on the pop edge while full, with a fresh tick phase
        reset = 1'b0;
        waitCycles(2);
        reset = 1'b1;
        applyStimulus(10'd10, 10'd10, 1'b1);     waitCycles(1);
        applyStimulus(10'd1016, 10'd1016, 1'b1); waitCycles(1);
        applyStimulus(10'd50, 10'd10, 1'b1);     waitCycles(1);
        applyStimulus(10'd80, 10'd10, 1'b1);
        waitCycles(5);
        checkOutput("t034_full_before", bomb_count, 4);
        applyStimulus(10'd120, 10'd125, 1'b1);
        checkOutput("t034_pop_strobe", explosion_write_enable, 1);
        checkOutput("t034_count_swap", bomb_count, 4);
        waitDrain("t034_drain", 60);
        checkOutput("t034_count_empty", bomb_count, 0);

        // Reset with two live bombs discards them silently
        applyStimulus(10'd200, 10'd40, 1'b1); waitCycles(1);
        applyStimulus(10'd240, 10'd40, 1'b1);
        checkOutput("t036_two_live", bomb_count, 2);
        reset = 1'b0;
        exp_q.delete();
        #1;
        checkOutput("t036_async_count", bomb_count, 0);
        checkOutput("t036_async_strobe", explosion_write_enable, 0);
        checkOutput("t036_async_ex_x", exploding_bomb_x, 0);
        waitCycles(2);
        reset = 1'b1;
        waitCycles(30);
        checkOutput("t036_quiet_count", bomb_count, 0);
        applyStimulus(10'd200, 10'd100, 1'b1);
        waitDrain("t036_fresh_drain", 40);
        checkOutput("t036_fresh_ex_x", exploding_bomb_x, 208);
        checkOutput("t036_fresh_ex_y", exploding_bomb_y, 96);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bomb_queue.md
BOMB_QUEUE -- requirements
Module: bomb_queue

Interface
REQ-001 Parameter MAX_BOMBS, default 4, SHALL set the number of simultaneously live bombs (power of two, 2..8).
REQ-002 Parameter FUSE_TICKS, default 120, SHALL set the ticks from placement to detonation (1..255).
REQ-003 Parameter TICK_DIV, default 833333, SHALL set the clk cycles per fuse tick (>=2).
REQ-004 Port clk, input, 1: the single system clock; all state is on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port C, input, 1: user bomb-place request (level; rising edge acts).
REQ-007 Ports b_x, b_y, input, 10 each: bomberman sprite top-left, in pixels.
REQ-008 Ports v_x, v_y, input, 10 each: current pixel location.
REQ-009 Ports exploding_bomb_x, exploding_bomb_y, output, 10 each: tile of the most recently detonated bomb.
REQ-010 Port explosion_write_enable, output, 1: single-cycle detonation strobe.
REQ-011 Port bomb_on, output, 1: current pixel lies inside a live bomb tile.
REQ-012 Ports bomb_col, bomb_row, output, 4 each: pixel offset within that tile, 0 when bomb_on=0.
REQ-013 Port bomb_count, output, 4: number of live bombs.

Function
REQ-014 Place event SHALL be C=1 while registered C_q=0; holding C SHALL produce exactly one event.
REQ-015 Placement tile SHALL be ((b_x+8) & 0x3F0, (b_y+8) & 0x3F0), i.e. sprite centre snapped to 16-px grid, 10-bit arithmetic.
REQ-016 Storage SHALL be a circular FIFO of MAX_BOMBS slots (valid, x, y, 8-bit fuse); head = oldest.
REQ-017 An accepted place event SHALL write the tail slot with fuse=FUSE_TICKS on the same edge; bomb_count SHALL reflect it the next cycle.
REQ-018 A place event SHALL be rejected silently when FIFO is full (and no pop that cycle) or when any valid slot holds the same tile.
REQ-019 A tick strobe SHALL occur once every TICK_DIV cycles; on a tick every valid slot with fuse>0 SHALL decrement by 1.
REQ-020 When head is valid with fuse=0, on that edge the head SHALL pop, exploding_bomb_x/y SHALL load its tile, and explosion_write_enable SHALL be 1 for exactly the following cycle.
REQ-021 At most one pop per cycle; further expired slots SHALL pop on successive cycles, one strobe each.
REQ-022 Push and pop in the same cycle SHALL both occur, including when full; bomb_count then unchanged.
REQ-023 A slot pushed on a tick edge SHALL load FUSE_TICKS undecremented.
REQ-024 Head and tail pointers SHALL wrap modulo MAX_BOMBS.
REQ-025 bomb_on SHALL be combinational: 1 iff some valid slot has x<=v_x<=x+15 and y<=v_y<=y+15; bomb_col/row = v_x-x, v_y-y of the lowest-index matching slot.
REQ-026 exploding_bomb_x/y SHALL hold their last value between strobes.

Reset
REQ-027 reset=0 SHALL asynchronously clear: all valid bits, pointers, fuses, C_q, tick prescaler, exploding_bomb_x/y=0, explosion_write_enable=0, bomb_count=0.
REQ-028 Reset mid-fuse SHALL discard all bombs with no strobe; the first tick after release SHALL come TICK_DIV cycles later.

Structure
REQ-029 Package bomberman_pkg SHALL hold TILE_W=16, TILE_H=16, TILE_MASK=10'h3F0 and the slot record type.
REQ-030 Tick prescaler SHALL be a sub-module tick_gen (parameter TICK_DIV, output 1-cycle tick).

Verification (MAX_BOMBS=4, FUSE_TICKS=3, TICK_DIV=4)
REQ-031 Place at b=(100,50) -> slot tile (96,48); strobe with exploding=(96,48) 12-16 cycles later; bomb_count 1->0.
REQ-032 C held 40 cycles -> exactly one bomb; second press at same b -> rejected, bomb_count stays 1.
REQ-033 Five places at distinct tiles within 8 cycles -> four accepted, fifth rejected; four strobes in placement order.
REQ-034 Place on the cycle head pops while full -> both occur, bomb_count stays 4, new tile later strobes.
REQ-035 v=(100,60) with live bomb at (96,48) -> bomb_on=1, col=4, row=12; v=(112,48) -> bomb_on=0.
REQ-036 reset=0 with 2 live bombs -> count=0, no strobe; after release the next strobe follows a fresh place only.
